// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch/predict slice:
//   - opcodes that the fetch stage predecodes (j, beq)
//   - 2-bit saturating counter encodings and the predictor reset value
//   - sat2(): one step of a 2-bit saturating counter
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BEQ = 6'b000100;

  // Counter encodings; the MSB is the taken/not-taken prediction.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = WNT;

  // Move one step toward the observed outcome, sticking at either end.
  function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
    logic [1:0] result;
    result = cnt;
    if (taken && (cnt != ST)) begin
      result = cnt + 2'd1;
    end else if (!taken && (cnt != SNT)) begin
      result = cnt - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
// Table of 2-bit saturating branch counters.
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset (all -> WNT)
//   rd_idx_i / rd_cnt_o  combinational read port used by fetch
//   upd_en_i, upd_idx_i,
//   upd_taken_i          synchronous update port driven by branch resolution
// A read and an update of the same entry in one cycle returns the old value;
// the new value is seen from the following cycle.
// ---------------------------------------------------------------------------
module bht_2bit
  import fetch_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_cnt_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] r_cnt [ENTRIES];

  assign rd_cnt_o = r_cnt[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_cnt[i] <= BHT_RESET;
      end
    end else if (upd_en_i) begin
      r_cnt[upd_idx_i] <= sat2(r_cnt[upd_idx_i], upd_taken_i);
    end
  end

endmodule

// File: rtl/fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// fetch_predict_unit
// Fetch stage with PC register, predecode of j/beq, static j resolution and
// dynamic beq prediction through a 2-bit counter table, plus recovery from
// mispredicts reported by ID and branch/mispredict statistics.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   start_i, stall_i        run enable / hazard stall (both hold the PC)
//   pc_o, inst_i            fetch address and fetched word
//   pred_taken_o            prediction for the word being fetched
//   res_*                   beq resolution from ID
//   redirect_o              mispredict this cycle; flush IF/ID
//   branch_cnt_o,
//   mispred_cnt_o           saturating statistics counters
// ---------------------------------------------------------------------------
module fetch_predict_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BHT_ENTRIES = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             stall_i,
  output logic [XLEN-1:0]  pc_o,
  input  logic [31:0]      inst_i,
  output logic             pred_taken_o,
  input  logic             res_valid_i,
  input  logic [XLEN-1:0]  res_pc_i,
  input  logic             res_taken_i,
  input  logic             res_pred_i,
  input  logic [XLEN-1:0]  res_target_i,
  output logic             redirect_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [XLEN-1:0]  r_pc;
  logic [XLEN-1:0]  w_pcNext;
  logic [XLEN-1:0]  w_pc4;
  logic [XLEN-1:0]  w_brOff;
  logic [XLEN-1:0]  w_brTgt;
  logic [XLEN-1:0]  w_jTgt;
  logic             w_isJ;
  logic             w_isBeq;
  logic             w_mispredict;
  logic [1:0]       w_cnt;
  logic [CNT_W-1:0] r_branchCnt;
  logic [CNT_W-1:0] r_mispredCnt;

  assign w_isJ   = (inst_i[31:26] == OP_J);
  assign w_isBeq = (inst_i[31:26] == OP_BEQ);

  // PC bits [1:0] are always zero for word fetches, so the table is indexed
  // from bit 2 upward; fetch and resolution use the same slice.
  bht_2bit #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .rd_idx_i    (r_pc[IDX_W+1:2]),
    .rd_cnt_o    (w_cnt),
    .upd_en_i    (res_valid_i),
    .upd_idx_i   (res_pc_i[IDX_W+1:2]),
    .upd_taken_i (res_taken_i)
  );

  assign pred_taken_o = w_isBeq & w_cnt[1];

  assign w_pc4   = r_pc + XLEN'(4);
  assign w_brOff = {{(XLEN-18){inst_i[15]}}, inst_i[15:0], 2'b00};
  assign w_brTgt = w_pc4 + w_brOff;
  assign w_jTgt  = {w_pc4[XLEN-1:28], inst_i[25:0], 2'b00};

  assign w_mispredict = res_valid_i & (res_taken_i != res_pred_i);
  assign redirect_o   = w_mispredict;

  // Recovery from ID outranks everything, including stall and start, since
  // whatever IF holds is on the wrong path anyway.
  always_comb begin
    w_pcNext = w_pc4;
    if (w_mispredict) begin
      w_pcNext = res_taken_i ? res_target_i : (res_pc_i + XLEN'(4));
    end else if (!start_i || stall_i) begin
      w_pcNext = r_pc;
    end else if (w_isJ) begin
      w_pcNext = w_jTgt;
    end else if (pred_taken_o) begin
      w_pcNext = w_brTgt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pcNext;
    end
  end

  // Statistics stick at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_branchCnt  <= '0;
      r_mispredCnt <= '0;
    end else begin
      if (res_valid_i && (r_branchCnt != '1)) begin
        r_branchCnt <= r_branchCnt + CNT_W'(1);
      end
      if (w_mispredict && (r_mispredCnt != '1)) begin
        r_mispredCnt <= r_mispredCnt + CNT_W'(1);
      end
    end
  end

  assign pc_o          = r_pc;
  assign branch_cnt_o  = r_branchCnt;
  assign mispred_cnt_o = r_mispredCnt;

endmodule

// File: tb/tb_fetch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_predict_unit
// Self-checking bench for fetch_predict_unit (4-entry table, 4-bit counters
// so that aliasing and counter saturation are reachable quickly).
// ---------------------------------------------------------------------------
module tb_fetch_predict_unit;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstN;
  logic             startI;
  logic             stallI;
  logic [XLEN-1:0]  pcO;
  logic [31:0]      instI;
  logic             predO;
  logic             resValid;
  logic [XLEN-1:0]  resPc;
  logic             resTaken;
  logic             resPred;
  logic [XLEN-1:0]  resTarget;
  logic             redirectO;
  logic [CNT_W-1:0] brCnt;
  logic [CNT_W-1:0] misCnt;

  int errCount   = 0;
  int checkCount = 0;

  // Reference model state
  logic [31:0] mPc;
  int          mBht [ENTRIES];
  int          mBr;
  int          mMis;

  always #5 clk = ~clk;

  fetch_predict_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .RESET_PC(32'h0), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rstN), .start_i(startI), .stall_i(stallI),
    .pc_o(pcO), .inst_i(instI), .pred_taken_o(predO),
    .res_valid_i(resValid), .res_pc_i(resPc), .res_taken_i(resTaken),
    .res_pred_i(resPred), .res_target_i(resTarget), .redirect_o(redirectO),
    .branch_cnt_o(brCnt), .mispred_cnt_o(misCnt)
  );

  function automatic int tableIdx(input logic [31:0] addr);
    return int'(addr / 4) % ENTRIES;
  endfunction

  function automatic logic modelPred();
    return (instI[31:26] == 6'd4) && (mBht[tableIdx(mPc)] >= 2);
  endfunction

  function automatic logic modelRedirect();
    return resValid && (resTaken != resPred);
  endfunction

  task automatic modelReset();
    mPc = 32'h0;
    for (int i = 0; i < ENTRIES; i++) mBht[i] = 1;
    mBr  = 0;
    mMis = 0;
  endtask

  // Advance the model by one clock from the current inputs, then wait for
  // the DUT edge and let outputs settle.
  task automatic tick();
    logic [31:0]        pc4;
    logic [31:0]        nxt;
    logic signed [31:0] off;
    logic               mis;
    int                 k;
    pc4 = mPc + 32'd4;
    off = {{16{instI[15]}}, instI[15:0]};
    mis = modelRedirect();
    if (mis)                     nxt = resTaken ? resTarget : resPc + 32'd4;
    else if (!startI || stallI)  nxt = mPc;
    else if (instI[31:26] == 6'd2) nxt = {pc4[31:28], instI[25:0], 2'b00};
    else if (modelPred())        nxt = pc4 + 32'(off * 4);
    else                         nxt = pc4;
    @(posedge clk);
    mPc = nxt;
    if (resValid) begin
      k = tableIdx(resPc);
      if (resTaken) mBht[k] = (mBht[k] < 3) ? mBht[k] + 1 : 3;
      else          mBht[k] = (mBht[k] > 0) ? mBht[k] - 1 : 0;
      if (mBr < CNT_MAX) mBr++;
    end
    if (mis && mMis < CNT_MAX) mMis++;
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p,
                               input logic t, input logic pr,
                               input logic [31:0] tg);
    resValid  = v;
    resPc     = p;
    resTaken  = t;
    resPred   = pr;
    resTarget = tg;
  endtask

  task automatic resetDut();
    startI = 1'b1;
    stallI = 1'b0;
    instI  = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rstN = 1'b0;
    #3;
    modelReset();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    startI = 1'b1; stallI = 1'b0; instI = 32'h0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rstN = 1'b0;
    #3;
    modelReset();
    checkCount++;
    if (pcO !== 32'h0) begin errCount++; $display("[TB] FAIL reset_pc got=%h want=0", pcO); end
    checkCount++;
    if (brCnt !== 4'h0 || misCnt !== 4'h0) begin
      errCount++; $display("[TB] FAIL reset_cnt got=%h/%h want=0/0", brCnt, misCnt);
    end
    checkCount++;
    if (redirectO !== 1'b0) begin errCount++; $display("[TB] FAIL reset_redirect got=%b want=0", redirectO); end
    rstN = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkCount++;
      if (pcO !== 32'(i * 4)) begin errCount++; $display("[TB] FAIL seq_pc got=%h want=%h", pcO, i * 4); end
    end
    resetDut();
    startI = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (pcO !== 32'h0) begin errCount++; $display("[TB] FAIL start_hold got=%h want=0", pcO); end
    end
  endtask

  task automatic test_jump();
    $display("[TB] test_jump");
    resetDut();
    for (int i = 0; i < 4; i++) tick();
    checkCount++;
    if (pcO !== 32'h10) begin errCount++; $display("[TB] FAIL jump_start got=%h want=10", pcO); end
    instI = 32'h08000040;
    #1;
    checkCount++;
    if (predO !== 1'b0 || redirectO !== 1'b0) begin
      errCount++; $display("[TB] FAIL jump_flags got=%b%b want=00", predO, redirectO);
    end
    tick();
    checkCount++;
    if (pcO !== 32'h100 || pcO !== mPc) begin errCount++; $display("[TB] FAIL jump_pc got=%h want=100", pcO); end
  endtask

  task automatic test_branch();
    $display("[TB] test_branch");
    resetDut();
    for (int i = 0; i < 8; i++) tick();
    instI = 32'h10000003;
    #1;
    checkCount++;
    if (predO !== 1'b0) begin errCount++; $display("[TB] FAIL cold_pred got=%b want=0", predO); end
    tick();
    checkCount++;
    if (pcO !== 32'h24) begin errCount++; $display("[TB] FAIL cold_pc got=%h want=24", pcO); end
    instI = 32'h0;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'h30);
    #1;
    checkCount++;
    if (redirectO !== 1'b1) begin errCount++; $display("[TB] FAIL cold_redirect got=%b want=1", redirectO); end
    tick();
    resValid = 1'b0;
    checkCount++;
    if (pcO !== 32'h30 || misCnt !== 4'd1 || brCnt !== 4'd1) begin
      errCount++; $display("[TB] FAIL cold_resolve got=%h/%0d/%0d want=30/1/1", pcO, misCnt, brCnt);
    end
    // Jump back to 0x20 to refetch the now weakly-taken branch.
    instI = 32'h08000008;
    tick();
    instI = 32'h10000003;
    #1;
    checkCount++;
    if (pcO !== 32'h20 || predO !== 1'b1) begin
      errCount++; $display("[TB] FAIL warm_pred got=%h/%b want=20/1", pcO, predO);
    end
    tick();
    checkCount++;
    if (pcO !== 32'h30) begin errCount++; $display("[TB] FAIL warm_pc got=%h want=30", pcO); end
    instI = 32'h0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h20, 1'b1, 1'b1, 32'h30);
      #1;
      checkCount++;
      if (redirectO !== 1'b0) begin errCount++; $display("[TB] FAIL warm_redirect got=%b want=0", redirectO); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h20, 1'b0, 1'b1, 32'h30);
      #1;
      checkCount++;
      if (redirectO !== 1'b1) begin errCount++; $display("[TB] FAIL nt_redirect got=%b want=1", redirectO); end
      tick();
      checkCount++;
      if (pcO !== 32'h24) begin errCount++; $display("[TB] FAIL nt_pc got=%h want=24", pcO); end
    end
    resValid = 1'b0;
    instI = 32'h08000008;
    tick();
    instI = 32'h10000003;
    #1;
    checkCount++;
    if (predO !== 1'b0) begin errCount++; $display("[TB] FAIL nt_pred got=%b want=0", predO); end
    checkCount++;
    if (brCnt !== 4'd7 || misCnt !== 4'd3) begin
      errCount++; $display("[TB] FAIL branch_cnts got=%0d/%0d want=7/3", brCnt, misCnt);
    end
  endtask

  task automatic test_collision();
    $display("[TB] test_collision");
    resetDut();
    tick();
    stallI = 1'b1;
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h200);
    #1;
    checkCount++;
    if (redirectO !== 1'b1) begin errCount++; $display("[TB] FAIL stall_redirect got=%b want=1", redirectO); end
    tick();
    checkCount++;
    if (pcO !== 32'h200) begin errCount++; $display("[TB] FAIL stall_pc got=%h want=200", pcO); end
    // Entry 0 is now weakly taken; fetch it while a not-taken update hits it.
    instI = 32'h10000003;
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
    #1;
    checkCount++;
    if (predO !== 1'b1) begin errCount++; $display("[TB] FAIL same_idx_old got=%b want=1", predO); end
    tick();
    resValid = 1'b0;
    #1;
    checkCount++;
    if (predO !== 1'b0 || pcO !== 32'h200) begin
      errCount++; $display("[TB] FAIL same_idx_new got=%b/%h want=0/200", predO, pcO);
    end
    stallI = 1'b0;
  endtask

  task automatic test_alias();
    $display("[TB] test_alias");
    resetDut();
    stallI = 1'b1;
    instI  = 32'h10000003;
    #1;
    checkCount++;
    if (predO !== 1'b0) begin errCount++; $display("[TB] FAIL alias_before got=%b want=0", predO); end
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h0);
    tick();
    tick();
    resValid = 1'b0;
    #1;
    checkCount++;
    if (predO !== 1'b1 || pcO !== 32'h0) begin
      errCount++; $display("[TB] FAIL alias_after got=%b/%h want=1/0", predO, pcO);
    end
    stallI = 1'b0;
  endtask

  task automatic test_saturation();
    $display("[TB] test_saturation");
    resetDut();
    instI = 32'h0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'h80, i[0], ~i[0], 32'h300);
      tick();
    end
    resValid = 1'b0;
    checkCount++;
    if (misCnt !== 4'hF || brCnt !== 4'hF) begin
      errCount++; $display("[TB] FAIL cnt_saturate got=%h/%h want=f/f", misCnt, brCnt);
    end
  endtask

  task automatic test_random();
    int sel;
    $display("[TB] test_random");
    resetDut();
    for (int n = 0; n < 400; n++) begin
      startI = ($urandom % 8) != 0;
      stallI = ($urandom % 5) == 0;
      sel = $urandom % 4;
      case (sel)
        0: instI = 32'h0;
        1: instI = {6'b000010, 26'($urandom % 64)};
        2: instI = {6'b000100, 10'($urandom), 16'($signed($urandom_range(0, 16)) - 8)};
        default: instI = $urandom;
      endcase
      applyStimulus(($urandom % 3) == 0, 32'($urandom % 64) * 4, 1'($urandom),
                    1'($urandom), 32'($urandom % 256) * 4);
      #1;
      checkCount++;
      if (predO !== modelPred() || redirectO !== modelRedirect()) begin
        errCount++;
        $display("[TB] FAIL rnd_comb n=%0d got=%b%b want=%b%b", n, predO, redirectO, modelPred(), modelRedirect());
      end
      tick();
      checkCount++;
      if (pcO !== mPc || brCnt !== 4'(mBr) || misCnt !== 4'(mMis)) begin
        errCount++;
        $display("[TB] FAIL rnd_state n=%0d got=%h/%0d/%0d want=%h/%0d/%0d", n, pcO, brCnt, misCnt, mPc, mBr, mMis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_branch();
    test_collision();
    test_alias();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
